// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline skid register: state encoding,
// default payload width and the bubble (NOP) payload constant.
package pipe_skid_reg_pkg;

  // Stage occupancy states; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int unsigned DEF_DATA_W = 128;

  // Bubble payload: an all-zero bundle decodes as a NOP downstream.
  localparam logic [DEF_DATA_W-1:0] DEF_NOP_VAL = {DEF_DATA_W{1'b0}};

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_of(input skid_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_BUSY:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: counts qualified cycles, sticks at all-ones,
// cleared only by reset.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register: an output register plus a skid
// register that catches the entry accepted in the cycle downstream stalls.
// in_ready, out_valid and occupancy all come straight from flops, so there
// is no combinational path from out_ready to in_ready.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned       DATA_W          = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VAL         = DATA_W'(DEF_NOP_VAL),
  parameter bit                CLEAR_ON_BUBBLE = 1'b1,
  parameter int unsigned       CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occupancy_q, occupancy_d;
  logic              stall_inc;

  // Next-state and payload steering; flush overrides every transition.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      skid_d  = NOP_VAL;
      if (CLEAR_ON_BUBBLE) begin
        out_data_d = NOP_VAL;
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            out_data_d = in_data;
            state_d    = ST_BUSY;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (in_valid && out_ready) begin
            out_data_d = in_data;
          end else if (!in_valid && out_ready) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_BUBBLE) begin
              out_data_d = NOP_VAL;
            end else begin
              out_data_d = out_data_q;
            end
          end else if (in_valid && !out_ready) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so in_valid is deliberately ignored.
          if (out_ready) begin
            out_data_d = skid_q;
            skid_d     = NOP_VAL;
            state_d    = ST_BUSY;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          out_data_d = NOP_VAL;
          skid_d     = NOP_VAL;
        end
      endcase
    end
  end

  // Handshake outputs derived from the next state so they can be registered.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    occupancy_d = occ_of(state_d);
  end

  // State, payload and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= NOP_VAL;
      skid_q      <= NOP_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      occupancy_q <= occupancy_d;
    end
  end

  // A flushed cycle is not back-pressure, even if downstream was stalled.
  assign stall_inc = out_valid_q & ~out_ready & ~flush;

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus a long randomized run,
// all checked against a queue-based model of a two-entry in-order buffer.
module tb_pipe_skid_reg;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cycles;

  logic          in_ready4, out_valid4;
  logic [DW-1:0] out_data4;
  logic [1:0]    occupancy4;
  logic [3:0]    stall_cycles4;

  int checks   = 0;
  int failures = 0;

  // Reference model: held entries, oldest first, plus stall counters.
  logic [DW-1:0] mq[$];
  int unsigned   m_stall16;
  int unsigned   m_stall4;
  int unsigned   seq = 0;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  pipe_skid_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cycles(stall_cycles4)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] exp_data;
    int n;
    n = mq.size();
    exp_data = (n > 0) ? mq[0] : {DW{1'b0}};
    check_val("out_valid", out_valid, n > 0);
    check_val("in_ready", in_ready, n < 2);
    check_val("occupancy", occupancy, n);
    check_val("out_data", out_data, exp_data);
    check_val("stall16", stall_cycles, m_stall16);
    check_val("stall4", stall_cycles4, m_stall4);
  endtask

  task automatic model_edge();
    int n;
    bit ov, ir;
    n  = mq.size();
    ov = (n > 0);
    ir = (n < 2);
    if (ov && !out_ready && !flush) begin
      if (m_stall16 < 65535) m_stall16++;
      if (m_stall4 < 15) m_stall4++;
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (ov && out_ready) void'(mq.pop_front());
      if (in_valid && ir) mq.push_back(in_data);
    end
  endtask

  task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset applied between edges; outputs must react at once.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    #1;
    mq.delete();
    m_stall16 = 0;
    m_stall4  = 0;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_occupancy", occupancy, 2'd0);
    check_val("rst_out_data", out_data, {DW{1'b0}});
    check_val("rst_stall", stall_cycles, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  function automatic logic [DW-1:0] rnd_data();
    seq++;
    return {$urandom(), $urandom(), $urandom(), seq[31:0]};
  endfunction

  initial begin
    logic [DW-1:0] a, b, c;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    m_stall16 = 0; m_stall4 = 0;
    #2;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs();

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DW'(i), 1'b1, 1'b0);
      check_val("stream_data", out_data, DW'(i));
      check_val("stream_occ", occupancy, 2'd1);
    end
    check_val("stream_stall", stall_cycles, 16'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: A, B held, C refused, then drain in order.
    do_reset();
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b0);
    check_val("bp_occ", occupancy, 2'd2);
    check_val("bp_in_ready", in_ready, 1'b0);
    check_val("bp_head", out_data, a);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("bp_second", out_data, b);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("bp_drained", out_valid, 1'b0);
    check_val("bp_stall", stall_cycles, 16'd3);

    // Flush while FULL with C offered: nothing survives.
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b1);
    check_val("flush_valid", out_valid, 1'b0);
    check_val("flush_occ", occupancy, 2'd0);
    check_val("flush_data", out_data, {DW{1'b0}});
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset while FULL.
    cycle(1'b1, rnd_data(), 1'b0, 1'b0);
    cycle(1'b1, rnd_data(), 1'b0, 1'b0);
    check_val("prerst_occ", occupancy, 2'd2);
    do_reset();

    // Saturation of the 4-bit stall counter.
    cycle(1'b1, rnd_data(), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    check_val("sat_15", stall_cycles4, 4'd15);
    check_val("sat_wide", stall_cycles, 16'd20);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    check_val("sat_hold", stall_cycles4, 4'd15);
    do_reset();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 3) != 0), rnd_data(), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning payload width (packed stage bundle: pc, inst, aluop, alusel, operands, wd, wreg, link, delay-slot flags).
REQ-002 SHALL have parameter NOP_VAL, default all-zero DATA_W vector, meaning the bubble payload presented when no valid entry is output.
REQ-003 SHALL have parameter CLEAR_ON_BUBBLE, default 1, meaning out_data is forced to NOP_VAL whenever out_valid=0 (0: hold last value).
REQ-004 SHALL have parameter CNT_W, default 16, meaning stall counter width.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port flush  input  1  discard all held entries and the current input.
REQ-008 SHALL have port in_valid  input  1  upstream entry present.
REQ-009 SHALL have port in_ready  output  1  stage can accept; registered.
REQ-010 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-011 SHALL have port out_valid  output  1  downstream entry present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-014 SHALL have port occupancy  output  2  held entries, 0..2.
REQ-015 SHALL have port stall_cycles  output  CNT_W  count of back-pressure cycles.

Function
REQ-016 SHALL transfer upstream when in_valid & in_ready, downstream when out_valid & out_ready.
REQ-017 SHALL hold state EMPTY (occ 0), BUSY (output reg valid, occ 1), FULL (output + skid reg valid, occ 2).
REQ-018 SHALL give 1-cycle latency: entry accepted at edge N appears on out_valid/out_data after edge N.
REQ-019 EMPTY: in_valid -> load output reg, go BUSY; else stay.
REQ-020 BUSY: in_valid & out_ready -> output reg replaced, stay BUSY; !in_valid & out_ready -> EMPTY; in_valid & !out_ready -> in_data into skid reg, FULL; neither -> stay.
REQ-021 FULL: in_ready=0, in_valid ignored; out_ready -> skid moves to output reg, BUSY; else stay.
REQ-022 SHALL drive in_ready=1 in EMPTY and BUSY, 0 in FULL, from a register (no combinational out_ready->in_ready path).
REQ-023 SHALL deliver entries in order, each exactly once; no loss under any in_valid/out_ready pattern.
REQ-024 SHALL keep out_data stable while out_valid & !out_ready.
REQ-025 flush SHALL take priority over every transition: next state EMPTY, out_valid=0, occupancy=0, in_data of the flush cycle discarded.
REQ-026 flush with out_valid & out_ready in the same cycle SHALL count that downstream transfer as completed.
REQ-027 CLEAR_ON_BUBBLE=1: out_data SHALL equal NOP_VAL whenever out_valid=0, including after flush and reset.
REQ-028 stall_cycles SHALL increment by 1 each cycle with out_valid & !out_ready & !flush, saturate at all-ones, never wrap, clear only on rst.

Reset
REQ-029 rst high SHALL immediately force EMPTY, out_valid=0, in_ready=1, occupancy=0, stall_cycles=0, out_data=NOP_VAL, skid reg=NOP_VAL.
REQ-030 rst asserted mid-transfer SHALL drop held entries; first edge after release behaves as EMPTY.

Structure
REQ-031 State encodings (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and default NOP payload constant SHALL live in the shared defines header.
REQ-032 Saturating counter SHALL be one sub-module, pipe_sat_cnt (params CNT_W; ports clk, rst, inc, count).

Verification
REQ-033 Reset: rst=1 mid-FULL -> same cycle out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-034 Streaming: in_valid=1, out_ready=1 with data 1..8 -> out_data 1..8 one cycle later, occupancy=1, stall_cycles=0.
REQ-035 Back-pressure: send A,B with out_ready=0 for 3 cycles -> occupancy 2, in_ready=0, C held off; out_ready=1 -> A then B, stall_cycles=3.
REQ-036 Flush in FULL with in_valid=1 data C -> next cycle out_valid=0, occupancy=0, C never emitted, out_data=NOP_VAL.
REQ-037 Saturation with CNT_W=4: out_ready=0 for 20 cycles while valid -> stall_cycles=15, holds 15.
REQ-038 Random in_valid/out_ready 10k cycles, scoreboard -> in-order, no loss/duplicate, out_data stable under stall.
